// File: rtl/pfb_deadlock_aggregator.sv
// Dataflow deadlock aggregator: declares deadlock when every non-idle process stays blocked
// for THRESHOLD consecutive cycles. The optional timestamp is enabled by PFB_DEADLOCK_TIMESTAMP_EN.
module pfb_deadlock_aggregator #(
   parameter int N_PROC    = 3,
   parameter int THRESHOLD = 16,
   parameter int CNT_W     = 8,
   parameter int IDX_W     = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [N_PROC-1:0] proc_block,
   input  logic [N_PROC-1:0] proc_idle,
   input  logic              clear,
   output logic              deadlock,
   output logic              deadlock_pulse,
   output logic [N_PROC-1:0] block_snapshot,
   output logic [IDX_W-1:0]  first_idx,
   output logic [CNT_W-1:0]  stall_cnt
`ifdef PFB_DEADLOCK_TIMESTAMP_EN
   ,
   output logic [31:0]       detect_cycle
`endif
);

   typedef enum logic [1:0] {IDLE, WATCH, CONFIRMED} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic              r_deadlock, w_deadlock_next;
   logic              r_pulse;
   logic [N_PROC-1:0] r_snapshot, w_snapshot_next;
   logic [IDX_W-1:0]  r_first_idx, w_first_idx_next;
   logic [CNT_W-1:0]  r_stall_cnt, w_stall_cnt_next;
   logic              w_stall;
   logic              w_enter;
   logic [IDX_W-1:0]  w_low_idx;

   // All-idle is not a stall: at least one process must actually be blocked.
   assign w_stall = (&(proc_block | proc_idle)) && (|proc_block);

   always_comb begin
      w_low_idx = '0;
      for (int i = N_PROC - 1; i >= 0; i--) begin
         if (proc_block[i]) w_low_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_deadlock  <= 1'b0;
         r_pulse     <= 1'b0;
         r_snapshot  <= '0;
         r_first_idx <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state     <= w_state_next;
         r_deadlock  <= w_deadlock_next;
         r_pulse     <= w_enter;
         r_snapshot  <= w_snapshot_next;
         r_first_idx <= w_first_idx_next;
         r_stall_cnt <= w_stall_cnt_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_deadlock_next  = r_deadlock;
      w_snapshot_next  = r_snapshot;
      w_first_idx_next = r_first_idx;
      w_stall_cnt_next = r_stall_cnt;
      w_enter          = 1'b0;
      if (clear) begin
         w_state_next     = IDLE;
         w_deadlock_next  = 1'b0;
         w_stall_cnt_next = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_stall) begin
                  w_first_idx_next = w_low_idx;
                  w_stall_cnt_next = CNT_W'(1);
                  if (THRESHOLD == 1) w_enter = 1'b1;
                  else                w_state_next = WATCH;
               end else begin
                  w_stall_cnt_next = '0;
               end
            end
            WATCH: begin
               if (!w_stall) begin
                  w_state_next     = IDLE;
                  w_stall_cnt_next = '0;
               end else if (r_stall_cnt == CNT_W'(THRESHOLD - 1)) begin
                  w_enter = 1'b1;
               end else begin
                  w_stall_cnt_next = r_stall_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
         // Detection entry overrides the per-state updates above.
         if (w_enter) begin
            w_state_next     = CONFIRMED;
            w_deadlock_next  = 1'b1;
            w_snapshot_next  = proc_block;
            w_stall_cnt_next = CNT_W'(THRESHOLD);
         end
      end
   end

   assign deadlock       = r_deadlock;
   assign deadlock_pulse = r_pulse;
   assign block_snapshot = r_snapshot;
   assign first_idx      = r_first_idx;
   assign stall_cnt      = r_stall_cnt;

`ifdef PFB_DEADLOCK_TIMESTAMP_EN
   logic [31:0] r_cycle;
   logic [31:0] r_detect_cycle;

   // Free-running cycle counter; detect_cycle survives clear and only reset zeroes it.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cycle        <= '0;
         r_detect_cycle <= '0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         if (w_enter) r_detect_cycle <= r_cycle;
      end
   end

   assign detect_cycle = r_detect_cycle;
`endif

endmodule

// File: tb/tb_pfb_deadlock_aggregator.sv
// Bench for pfb_deadlock_aggregator: table of vector records feeding a scoreboard queue,
// plus hand sequences for reset mid-window and a THRESHOLD=1 instance.
module tb_pfb_deadlock_aggregator;

   typedef struct packed {
      logic        dl;
      logic        pulse;
      logic [7:0]  cnt;
      logic [2:0]  snap;
      logic [1:0]  first;
      logic        chk_ts;
      logic [31:0] ts;
   } exp_t;

   typedef struct packed {
      logic [2:0] blk;
      logic [2:0] idl;
      logic       clr;
      logic [7:0] reps;
      exp_t       e;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  blk = '0, idl = '0, blk1 = '0, idl1 = '0;
   logic        clr = 1'b0, clr1 = 1'b0;
   logic        dl, pulse, dl1, pulse1;
   logic [2:0]  snap, snap1;
   logic [1:0]  first, first1;
   logic [7:0]  cnt, cnt1;
   logic [31:0] ts, ts1;

   int   passed = 0;
   int   total  = 0;
   exp_t sb[$];
   vec_t vecs[$];

   always #5 clock = ~clock;

   pfb_deadlock_aggregator #(.N_PROC(3), .THRESHOLD(16), .CNT_W(8), .IDX_W(2)) dut (
      .clock(clock), .reset(reset), .proc_block(blk), .proc_idle(idl), .clear(clr),
      .deadlock(dl), .deadlock_pulse(pulse), .block_snapshot(snap), .first_idx(first),
      .stall_cnt(cnt)
`ifdef PFB_DEADLOCK_TIMESTAMP_EN
      , .detect_cycle(ts)
`endif
   );

   pfb_deadlock_aggregator #(.N_PROC(3), .THRESHOLD(1), .CNT_W(8), .IDX_W(2)) dut1 (
      .clock(clock), .reset(reset), .proc_block(blk1), .proc_idle(idl1), .clear(clr1),
      .deadlock(dl1), .deadlock_pulse(pulse1), .block_snapshot(snap1), .first_idx(first1),
      .stall_cnt(cnt1)
`ifdef PFB_DEADLOCK_TIMESTAMP_EN
      , .detect_cycle(ts1)
`endif
   );

`ifndef PFB_DEADLOCK_TIMESTAMP_EN
   assign ts  = '0;
   assign ts1 = '0;
`endif

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
      else passed++;
   endtask

   function automatic exp_t mk_e(input logic d, input logic p, input logic [7:0] c,
                                 input logic [2:0] s, input logic [1:0] f,
                                 input logic ck, input logic [31:0] t);
      exp_t e;
      e.dl = d; e.pulse = p; e.cnt = c; e.snap = s; e.first = f; e.chk_ts = ck; e.ts = t;
      return e;
   endfunction

   function automatic vec_t mk_v(input logic [2:0] b, input logic [2:0] i, input logic c,
                                 input logic [7:0] n, input exp_t e);
      vec_t v;
      v.blk = b; v.idl = i; v.clr = c; v.reps = n; v.e = e;
      return v;
   endfunction

   // One clock: drive on the falling edge, optionally queue an expectation, compare after the edge.
   task automatic step(input logic r, input logic [2:0] b, input logic [2:0] i, input logic c,
                       input bit push, input exp_t e);
      exp_t got;
      @(negedge clock);
      reset = r; blk = b; idl = i; clr = c;
      if (push) sb.push_back(e);
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
         got = sb.pop_front();
         check("deadlock", {31'd0, dl}, {31'd0, got.dl});
         check("pulse", {31'd0, pulse}, {31'd0, got.pulse});
         check("stall_cnt", {24'd0, cnt}, {24'd0, got.cnt});
         check("snapshot", {29'd0, snap}, {29'd0, got.snap});
         check("first_idx", {30'd0, first}, {30'd0, got.first});
`ifdef PFB_DEADLOCK_TIMESTAMP_EN
         if (got.chk_ts) check("detect_cycle", ts, got.ts);
`endif
      end
   endtask

   initial begin
      exp_t none;
      none = '0;
      // Basic detection (stall from cycle 10), sticky flag, clear.
      vecs.push_back(mk_v(3'b000, 3'b000, 0,  10, mk_e(0, 0,  0, 3'b000, 0, 0, 0)));
      vecs.push_back(mk_v(3'b100, 3'b011, 0,  15, mk_e(0, 0, 15, 3'b000, 2, 0, 0)));
      vecs.push_back(mk_v(3'b100, 3'b011, 0,   1, mk_e(1, 1, 16, 3'b100, 2, 1, 25)));
      vecs.push_back(mk_v(3'b100, 3'b011, 0,   1, mk_e(1, 0, 16, 3'b100, 2, 0, 0)));
      vecs.push_back(mk_v(3'b000, 3'b000, 0,   5, mk_e(1, 0, 16, 3'b100, 2, 0, 0)));
      vecs.push_back(mk_v(3'b000, 3'b000, 1,   1, mk_e(0, 0,  0, 3'b100, 2, 1, 25)));
      vecs.push_back(mk_v(3'b000, 3'b000, 0,   1, mk_e(0, 0,  0, 3'b100, 2, 0, 0)));
      // Window restart after a one-cycle gap; pattern change mid-window keeps counting.
      vecs.push_back(mk_v(3'b001, 3'b110, 0,  15, mk_e(0, 0, 15, 3'b100, 0, 0, 0)));
      vecs.push_back(mk_v(3'b000, 3'b110, 0,   1, mk_e(0, 0,  0, 3'b100, 0, 0, 0)));
      vecs.push_back(mk_v(3'b110, 3'b001, 0,  15, mk_e(0, 0, 15, 3'b100, 1, 0, 0)));
      vecs.push_back(mk_v(3'b010, 3'b101, 0,   1, mk_e(1, 1, 16, 3'b010, 1, 0, 0)));
      vecs.push_back(mk_v(3'b000, 3'b000, 1,   1, mk_e(0, 0,  0, 3'b010, 1, 0, 0)));
      // All idle is never a stall.
      vecs.push_back(mk_v(3'b000, 3'b111, 0, 100, mk_e(0, 0,  0, 3'b010, 1, 0, 0)));
      // Clear coincident with the detecting cycle wins.
      vecs.push_back(mk_v(3'b100, 3'b011, 0,  15, mk_e(0, 0, 15, 3'b010, 2, 0, 0)));
      vecs.push_back(mk_v(3'b100, 3'b011, 1,   1, mk_e(0, 0,  0, 3'b010, 2, 0, 0)));
      vecs.push_back(mk_v(3'b100, 3'b011, 0,   1, mk_e(0, 0,  1, 3'b010, 2, 0, 0)));

      step(1, 3'b000, 3'b000, 0, 0, none);
      step(1, 3'b000, 3'b000, 0, 1, mk_e(0, 0, 0, 3'b000, 0, 1, 0));

      foreach (vecs[k]) begin
         for (int n = 0; n < int'(vecs[k].reps); n++)
            step(0, vecs[k].blk, vecs[k].idl, vecs[k].clr, n == int'(vecs[k].reps) - 1, vecs[k].e);
      end

      // Reset in the middle of a watch window: everything returns to zero, count restarts.
      for (int n = 0; n < 3; n++) step(0, 3'b100, 3'b011, 0, 0, none);
      step(1, 3'b100, 3'b011, 0, 1, mk_e(0, 0, 0, 3'b000, 0, 1, 0));
      step(0, 3'b100, 3'b011, 0, 1, mk_e(0, 0, 1, 3'b000, 2, 0, 0));

      // THRESHOLD=1 instance: one stall cycle is enough.
      @(negedge clock); blk1 = 3'b010; idl1 = 3'b101;
      @(posedge clock); #1;
      check("t1_deadlock", {31'd0, dl1}, 32'd1);
      check("t1_pulse", {31'd0, pulse1}, 32'd1);
      check("t1_cnt", {24'd0, cnt1}, 32'd1);
      check("t1_snapshot", {29'd0, snap1}, 32'd2);
      check("t1_first", {30'd0, first1}, 32'd1);
      @(negedge clock); blk1 = 3'b000; idl1 = 3'b000;
      @(posedge clock); #1;
      check("t1_sticky", {31'd0, dl1}, 32'd1);
      check("t1_pulse_off", {31'd0, pulse1}, 32'd0);
      @(negedge clock); clr1 = 1'b1;
      @(posedge clock); #1;
      check("t1_cleared", {31'd0, dl1}, 32'd0);
      check("t1_cnt_clr", {24'd0, cnt1}, 32'd0);
      clr1 = 1'b0;

      if (sb.size() != 0) check("scoreboard_drain", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
